// File: rtl/dmx_universe_tx.sv
// DMX512 universe transmitter: channel buffer plus BREAK / MAB / slot framer
// with a frame-rate limiter that pads each frame up to the refresh period.
module dmx_universe_tx #(
    parameter int unsigned CLK_FREQ   = 12090000,
    parameter int unsigned BAUD_RATE  = 250000,
    parameter int unsigned NUM_CH     = 512,
    parameter int unsigned BREAK_US   = 176,
    parameter int unsigned MAB_US     = 12,
    parameter int unsigned REFRESH_HZ = 40,
    parameter logic [7:0]  START_CODE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [8:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BIT_CYC   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BREAK_CYC = (CLK_FREQ / 1000000) * BREAK_US;
    localparam int unsigned MAB_CYC   = (CLK_FREQ / 1000000) * MAB_US;
    localparam int unsigned FRAME_CYC = CLK_FREQ / REFRESH_HZ;
    localparam int          AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [31:0] BIT_LAST   = 32'(BIT_CYC - 1);
    localparam logic [31:0] BREAK_LAST = 32'(BREAK_CYC - 1);
    localparam logic [31:0] MAB_LAST   = 32'(MAB_CYC - 1);
    localparam logic [31:0] PERIOD_MAX = 32'(FRAME_CYC - 1);
    localparam logic [9:0]  NUM_CH_W   = 10'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE, BREAK, MAB, START_BIT, DATA, STOP, WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [2:0]  bit_q, bit_d;
    logic [9:0]  slot_q, slot_d;
    logic [7:0]  byte_q, byte_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [AW-1:0] rd_idx;

    logic [7:0] mem_q [NUM_CH];

    // Buffer is not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < NUM_CH_W)) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_idx = AW'(slot_q - 10'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        bit_d    = bit_q;
        slot_d   = slot_q;
        byte_d   = byte_q;
        done_d   = 1'b0;
        period_d = (period_q >= PERIOD_MAX) ? period_q : period_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (enable) state_d = BREAK;
            end
            BREAK: begin
                if (cnt_q == BREAK_LAST) state_d = MAB;
            end
            MAB: begin
                if (cnt_q == MAB_LAST) begin
                    state_d = START_BIT;
                    slot_d  = '0;
                end
            end
            START_BIT: begin
                // Latch on the first start-bit cycle; a write landing on the
                // same edge is seen only by the next frame.
                if (cnt_q == '0) begin
                    byte_d = (slot_q == '0) ? START_CODE : mem_q[rd_idx];
                end
                if (cnt_q == BIT_LAST) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd0) begin
                        bit_d = 3'd1;
                    end else begin
                        bit_d = '0;
                        if (slot_q == NUM_CH_W) begin
                            done_d = 1'b1;
                            slot_d = '0;
                            if (!enable)                    state_d = IDLE;
                            else if (period_q >= PERIOD_MAX) state_d = BREAK;
                            else                            state_d = WAIT;
                        end else begin
                            slot_d  = slot_q + 10'd1;
                            state_d = START_BIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (!enable)                     state_d = IDLE;
                else if (period_q >= PERIOD_MAX) state_d = BREAK;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_d == IDLE || state_d == WAIT) cnt_d = '0;
        if (state_d == IDLE || (state_d == BREAK && state_q != BREAK)) period_d = '0;

        // Outputs are registered from the next state so they line up with state_q.
        case (state_d)
            BREAK, START_BIT: tx_d = 1'b0;
            DATA:             tx_d = byte_d[bit_d];
            default:          tx_d = 1'b1;
        endcase
        busy_d = !(state_d == IDLE || state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            bit_q    <= '0;
            slot_q   <= '0;
            byte_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            bit_q    <= bit_d;
            slot_q   <= slot_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: doc/dmx_universe_tx.md
DMX_UNIVERSE_TX -- requirements
Module: dmx_universe_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12090000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 250000, slot bit rate in bit/s.
REQ-003 SHALL have parameter NUM_CH, default 512, data slots per frame; legal range 1..512.
REQ-004 SHALL have parameter BREAK_US, default 176, BREAK length in µs.
REQ-005 SHALL have parameter MAB_US, default 12, mark-after-break length in µs.
REQ-006 SHALL have parameter REFRESH_HZ, default 40, frame repetition rate.
REQ-007 SHALL have parameter START_CODE, default 8'h00, slot-0 value.
REQ-008 clk  input  1  system clock; one clock domain; all logic on its rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 enable  input  1  high: transmit frames continuously; low: finish current frame, then idle.
REQ-011 wr_en  input  1  channel-buffer write strobe.
REQ-012 wr_addr  input  9  channel index 0..NUM_CH-1; 0 maps to DMX slot 1.
REQ-013 wr_data  input  8  channel level.
REQ-014 tx  output  1  serial line to RS-485 driver; idle mark = 1.
REQ-015 busy  output  1  high from the first BREAK cycle through the last stop-bit cycle.
REQ-016 frame_done  output  1  one-cycle pulse on frame completion.

Function
REQ-017 Derived constants SHALL be: BIT_CYC = CLK_FREQ/BAUD_RATE; BREAK_CYC = (CLK_FREQ/1000000)*BREAK_US; MAB_CYC = (CLK_FREQ/1000000)*MAB_US; FRAME_CYC = CLK_FREQ/REFRESH_HZ; integer division throughout; BIT_CYC >= 2 required.
REQ-018 Channel buffer SHALL be NUM_CH x 8; a write SHALL occur when wr_en=1; writes with wr_addr >= NUM_CH SHALL be ignored; writes are accepted in every state.
REQ-019 FSM states SHALL be IDLE, BREAK, MAB, START_BIT, DATA, STOP, WAIT.
REQ-020 In IDLE with enable=1, the FSM SHALL enter BREAK on the next cycle; the period counter SHALL clear to 0 on entry to BREAK.
REQ-021 In BREAK, tx SHALL be 0 for exactly BREAK_CYC cycles; in MAB, tx SHALL be 1 for exactly MAB_CYC cycles.
REQ-022 Each slot SHALL be 11 bits of BIT_CYC cycles each: start bit 0, 8 data bits LSB first, 2 stop bits 1.
REQ-023 Slot 0 SHALL carry START_CODE; slots 1..NUM_CH SHALL carry buffer[0..NUM_CH-1]; frame length is BREAK_CYC+MAB_CYC+(NUM_CH+1)*11*BIT_CYC cycles.
REQ-024 A slot byte SHALL be latched from the buffer in the first START_BIT cycle; a same-cycle write to that address SHALL NOT affect the latched byte, and the new value goes out in the next frame.
REQ-025 Slots SHALL be back-to-back with no inter-slot mark.
REQ-026 frame_done SHALL pulse in the first cycle after the last stop bit of slot NUM_CH.
REQ-027 After the last stop bit: if enable=1 and the period counter >= FRAME_CYC-1, the FSM SHALL enter BREAK in the frame_done cycle; if enable=1 and the counter < FRAME_CYC-1, it SHALL enter WAIT; if enable=0, it SHALL enter IDLE.
REQ-028 WAIT SHALL hold tx=1 until the period counter reaches FRAME_CYC-1, then enter BREAK; if enable falls during WAIT, it SHALL enter IDLE on the next cycle.
REQ-029 enable=0 SHALL NOT truncate a frame in progress.
REQ-030 The period counter SHALL be 32 bits, saturate at FRAME_CYC-1, and stay at 0 in IDLE.
REQ-031 busy SHALL be 0 in IDLE, WAIT and the frame_done cycle unless BREAK is entered in that cycle.

Reset
REQ-032 With rst=1, the block SHALL enter IDLE, set tx=1, busy=0, frame_done=0, and clear the slot index and all counters on the next edge, including mid-frame.
REQ-033 Buffer contents SHALL NOT be cleared by rst; they are undefined after power-up.

Verification (CLK_FREQ=1000000, BAUD_RATE=250000, NUM_CH=3, BREAK_US=176, MAB_US=12, REFRESH_HZ=2000: BIT_CYC=4, FRAME_CYC=500, frame=364 cycles)
REQ-034 Assert rst for 2 cycles -> tx=1, busy=0, frame_done=0.
REQ-035 Write ch0=A5, ch1=01, ch2=FF, then raise enable -> tx low 176 cycles, high 12, slot 0 = 0 then eight 0s then 1,1, slot 1 bits 1,0,1,0,0,1,0,1; frame_done at frame cycle 364; next BREAK at cycle 500.
REQ-036 Drop enable during slot 2 -> frame completes, frame_done pulses, tx stays 1, no further BREAK.
REQ-037 Set REFRESH_HZ=4000 (FRAME_CYC=250 < 364) -> next BREAK starts in the frame_done cycle; busy never drops.
REQ-038 Write wr_addr=3 (out of range) and write ch0=3C during slot 2 -> current frame unchanged; next frame slot 1 = 3C.
REQ-039 Assert rst during slot 1 data -> tx=1 and busy=0 next cycle; after release with enable=1, a full frame restarts from BREAK.
